// File: rtl/count_seq_checker.sv
// count_seq_checker
//   Monitor for a free-running binary up-counter. It seeds on the first
//   sample, needs LOCK_CNT consecutive +1 matches to declare lock, and then
//   flags every break in the +1 sequence. It also reports in-sequence wraps
//   to zero and keeps a saturating tally of errors seen while locked.
//
//   Optional build macro: COUNT_CHECK_HOLD_EN. When it is defined, a repeat
//   of the previous value (count_in == exp_count - 1) in ACQUIRE or LOCKED
//   is treated as a tolerated stall: no error is flagged and all state holds.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous reset, active low
//   en          sample strobe; count_in is evaluated only when en=1
//   count_in    counter value under check (WIDTH bits)
//   err_clr     synchronous clear of err_count (acts even when en=0)
//   locked      high while in LOCKED
//   err_pulse   one-cycle flag on a mismatch while LOCKED
//   wrap_pulse  one-cycle flag on an in-sequence wrap to 0 while LOCKED
//   err_count   saturating 16-bit count of locked mismatches
//   exp_count   value expected on the next sample
//   last_bad    count_in captured at the most recent error
module count_seq_checker #(
  parameter int WIDTH    = 8,
  parameter int LOCK_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] count_in,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [15:0]      err_count,
  output logic [WIDTH-1:0] exp_count,
  output logic [WIDTH-1:0] last_bad
);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [3:0]       run, run_nxt;
  logic [WIDTH-1:0] exp_nxt, last_nxt;
  logic [15:0]      errc_nxt;
  logic             locked_nxt, errp_nxt, wrap_nxt;

  logic [WIDTH-1:0] seed;
  logic [3:0]       run_inc;
  logic             match, stall, err_hit;

  assign seed    = count_in + WIDTH'(1);
  assign run_inc = run + 4'd1;
  assign match   = (count_in == exp_count);

`ifdef COUNT_CHECK_HOLD_EN
  // A held counter presents its previous value again; expected is one ahead.
  assign stall = (state != IDLE) && (count_in == exp_count - WIDTH'(1));
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      run        <= '0;
      exp_count  <= '0;
      last_bad   <= '0;
      err_count  <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      run        <= run_nxt;
      exp_count  <= exp_nxt;
      last_bad   <= last_nxt;
      err_count  <= errc_nxt;
      locked     <= locked_nxt;
      err_pulse  <= errp_nxt;
      wrap_pulse <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    run_nxt    = run;
    exp_nxt    = exp_count;
    last_nxt   = last_bad;
    locked_nxt = locked;
    errp_nxt   = 1'b0;
    wrap_nxt   = 1'b0;
    err_hit    = 1'b0;

    if (en && !stall) begin
      case (state)
        IDLE: begin
          exp_nxt   = seed;
          run_nxt   = '0;
          state_nxt = ACQUIRE;
        end
        ACQUIRE: begin
          // Matches and mismatches both advance expectation from count_in;
          // a mismatch simply restarts the run.
          exp_nxt = seed;
          if (match) begin
            run_nxt = run_inc;
            if (run_inc == 4'(LOCK_CNT)) begin
              state_nxt  = LOCKED;
              locked_nxt = 1'b1;
            end
          end else begin
            run_nxt = '0;
          end
        end
        LOCKED: begin
          exp_nxt = seed;
          if (match) begin
            wrap_nxt = (count_in == '0);
          end else begin
            err_hit    = 1'b1;
            errp_nxt   = 1'b1;
            last_nxt   = count_in;
            locked_nxt = 1'b0;
            run_nxt    = '0;
            state_nxt  = ACQUIRE;
          end
        end
        default: begin
          state_nxt  = IDLE;
          locked_nxt = 1'b0;
        end
      endcase
    end

    // Clear wins over the accumulated tally but not over a same-cycle error.
    if (err_clr)
      errc_nxt = {15'd0, err_hit};
    else if (err_hit && err_count != 16'hFFFF)
      errc_nxt = err_count + 16'd1;
    else
      errc_nxt = err_count;
  end

endmodule

// File: tb/tb_count_seq_checker.sv
module tb_count_seq_checker;
  localparam int LOCK = 4;
`ifdef COUNT_CHECK_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0, en = 1'b0, err_clr = 1'b0;
  logic [7:0]  count_in = 8'd0;
  logic        locked, err_pulse, wrap_pulse;
  logic [15:0] err_count;
  logic [7:0]  exp_count, last_bad;

  count_seq_checker #(.WIDTH(8), .LOCK_CNT(LOCK)) dut (
    .clk(clk), .rst(rst), .en(en), .count_in(count_in), .err_clr(err_clr),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .exp_count(exp_count), .last_bad(last_bad)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  bit chk_on = 1'b0;

  // Reference model: phase 0 idle, 1 hunting for lock, 2 locked.
  int m_st = 0, m_run = 0, m_exp = 0, m_errc = 0, m_last = 0;
  bit m_errp = 0, m_wrap = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  // Apply the rules to one sampled edge using the inputs just driven.
  task automatic model_step();
    bit hit, stall;
    hit = 0;
    if (!rst) begin
      m_st = 0; m_run = 0; m_exp = 0; m_errc = 0; m_last = 0;
      m_errp = 0; m_wrap = 0;
      return;
    end
    m_errp = 0; m_wrap = 0;
    if (en) begin
      stall = HOLD && m_st != 0 && int'(count_in) == (m_exp + 255) % 256;
      if (m_st == 0) begin
        m_exp = (count_in + 1) % 256; m_run = 0; m_st = 1;
      end else if (!stall) begin
        if (int'(count_in) == m_exp) begin
          if (m_st == 1) begin
            m_run++;
            if (m_run == LOCK) m_st = 2;
          end else begin
            m_wrap = (count_in == 8'd0);
          end
        end else begin
          if (m_st == 2) begin hit = 1; m_errp = 1; m_last = count_in; end
          m_st = 1; m_run = 0;
        end
        m_exp = (count_in + 1) % 256;
      end
    end
    if (err_clr) m_errc = hit ? 1 : 0;
    else if (hit && m_errc < 65535) m_errc++;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("locked",     locked,     (m_st == 2));
      check("err_pulse",  err_pulse,  m_errp);
      check("wrap_pulse", wrap_pulse, m_wrap);
      check("err_count",  err_count,  m_errc);
      check("exp_count",  exp_count,  m_exp);
      check("last_bad",   last_bad,   m_last);
    end
  end

  task automatic cyc(input bit r, input bit e, input int c, input bit clr);
    rst = r; en = e; count_in = 8'(c); err_clr = clr;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic seq(input int from, input int n);
    for (int i = 0; i < n; i++) cyc(1, 1, (from + i) % 256, 0);
  endtask

  initial begin
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk_on = 1'b1;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check("rst_locked", locked, 0);
    check("rst_exp", exp_count, 0);
    check("rst_errc", err_count, 0);

    // Lock latency: seed + 4 matches
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, i, 0);
      check("lock_latency", locked, (i == 4));
    end
    check("lock_exp", exp_count, 5);
    cyc(1, 0, 77, 0);              // en=0 holds everything
    check("en0_hold_exp", exp_count, 5);
    check("en0_hold_lock", locked, 1);
    cyc(1, 1, 5, 0);

    // Wrap
    cyc(0, 0, 0, 0);
    seq(248, 5);
    check("lock253", exp_count, 253);
    seq(253, 3);
    check("nowrap255", wrap_pulse, 0);
    cyc(1, 1, 0, 0);
    check("wrap_at0", wrap_pulse, 1);
    cyc(1, 1, 1, 0);
    check("wrap_drop", wrap_pulse, 0);
    check("wrap_noerr", err_pulse, 0);

    // Skip error
    seq(2, 8);
    check("exp10", exp_count, 10);
    cyc(1, 1, 12, 0);
    check("skip_errp", err_pulse, 1);
    check("skip_errc", err_count, 1);
    check("skip_last", last_bad, 12);
    check("skip_unlock", locked, 0);
    check("skip_exp", exp_count, 13);
    cyc(1, 1, 13, 0);
    check("skip_errp_drop", err_pulse, 0);
    seq(14, 3);
    check("relock", locked, 1);
    check("relock_exp", exp_count, 17);

    // Repeat of previous value
    cyc(0, 0, 0, 0);
    seq(2, 5);
    check("exp7", exp_count, 7);
    cyc(1, 1, 6, 0);
`ifdef COUNT_CHECK_HOLD_EN
    check("stall_lock", locked, 1);
    check("stall_exp", exp_count, 7);
    check("stall_errc", err_count, 0);
`else
    check("repeat_lock", locked, 0);
    check("repeat_errc", err_count, 1);
    check("repeat_exp", exp_count, 7);
`endif
    seq(7, 4);
    check("lock_again", locked, 1);

    // Saturation: preload the tally, then one more error
    rst = 1; en = 0; count_in = 0; err_clr = 0;
    m_errc = 65535;
    force dut.err_count = 16'hFFFF;
    @(posedge clk);
    model_step();
    #1;
    release dut.err_count;
    check("preload", err_count, 16'hFFFF);
    cyc(1, 1, 50, 0);
    check("sat_errc", err_count, 16'hFFFF);
    check("sat_errp", err_pulse, 1);
    check("sat_last", last_bad, 50);
    seq(51, 4);
    check("sat_relock", locked, 1);
    cyc(1, 1, 99, 1);
    check("clr_and_err", err_count, 1);
    cyc(1, 0, 0, 1);
    check("clr_en0", err_count, 0);
    seq(100, 4);
    check("pre_rst_lock", locked, 1);
    cyc(0, 1, 104, 0);
    check("rst_lock", locked, 0);
    check("rst_exp2", exp_count, 0);
    check("rst_last", last_bad, 0);
    cyc(1, 0, 0, 0);

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/count_seq_checker.md
Name: count_seq_checker

Overview:
- Consumer-side checker for a free-running binary up-counter output, such as the 8-bit `counter_int` count bus.
- Samples the counter value, acquires lock on the +1 sequence, then flags skips, stalls and corruption.
- Reports wrap-around events and keeps a saturating error tally.
- Sits beside the counter in the design or the bench as a self-checking monitor.

Parameters:
- WIDTH, 8: width of the sampled count.
- LOCK_CNT, 4: consecutive +1 matches after the seed sample required to declare lock. Legal range 1..15.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low: sampled on the clk rising edge; rst=0 resets the block.
- en  in  1  sample strobe; count_in is evaluated only when en=1.
- count_in  in  WIDTH  counter value under check.
- err_clr  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle flag on a mismatch while LOCKED.
- wrap_pulse  out  1  one-cycle flag on an in-sequence wrap to 0 while LOCKED.
- err_count  out  16  saturating count of locked mismatches.
- exp_count  out  WIDTH  value expected on the next sample.
- last_bad  out  WIDTH  count_in captured at the most recent error.

Behaviour:
- Reset: if rst=0 at a clk edge, all state and outputs go to 0 and the state goes to IDLE. Reset has priority over en and err_clr, including mid-acquire and while LOCKED.
- All outputs are registered. Every response appears after the clk edge that sampled en=1.
- en=0: state, exp_count, run counter and err_count hold. err_pulse and wrap_pulse go to 0. err_clr still acts.
- Arithmetic: exp_count <= count_in + 1 mod 2^WIDTH, on every sampled cycle. Max value + 1 = 0.
- Match: count_in == exp_count. The run counter is 4 bits.
- FSM IDLE: on en, seed exp_count, set run=0, go to ACQUIRE.
- FSM ACQUIRE, match: run+1. If run+1 == LOCK_CNT, go to LOCKED and set locked=1 in the same update.
- FSM ACQUIRE, mismatch: reseed exp_count, run=0. No error is flagged and err_count is unchanged.
- FSM LOCKED, match: stay in LOCKED. If count_in == 0, wrap_pulse=1 for one cycle.
- FSM LOCKED, mismatch (with the optional feature disabled):
  - err_pulse=1 for one cycle.
  - last_bad <= count_in.
  - err_count+1, saturating at 16'hFFFF.
  - locked=0, next state ACQUIRE, exp_count reseeded from count_in, run=0.
- err_clr: err_count <= 0. If err_clr and a counted error occur in the same cycle, err_count <= 1.
- Lock latency: with LOCK_CNT=4, locked is 1 after the edge sampling the 5th consecutive sequential value (seed plus 4 matches).
- Pulses never stay high for two cycles unless two qualifying samples occur on consecutive edges.

Optional Feature:
- Macro: COUNT_CHECK_HOLD_EN.
- Defined: in ACQUIRE or LOCKED, count_in == exp_count - 1 (repeat of the previous value) is a tolerated stall.
  - No error is flagged.
  - State, run counter and exp_count are unchanged.
  - This covers a counter held in reset or gated.
- Not defined: a repeat is an ordinary mismatch.

Test Plan:
- rst=0 for 2 edges, then release; no en -> all outputs 0, state IDLE.
- en=1, count_in 0,1,2,3,4 on successive edges, LOCK_CNT=4 -> locked=0 after edges 1-4, locked=1 after edge 5, exp_count=5, err_count=0.
- Locked stream 253,254,255,0,1 -> wrap_pulse=1 for exactly the one cycle after the edge sampling 0; err_pulse stays 0.
- Locked at exp=10, drive 12 -> err_pulse=1 for one cycle, err_count=1, last_bad=12, locked=0, exp_count=13. Then 13,14,15,16 -> relock.
- Locked at exp=7, drive 6 -> without COUNT_CHECK_HOLD_EN: err_count+1, locked=0. With COUNT_CHECK_HOLD_EN: no error, locked stays 1, exp_count stays 7.
- err_count preloaded to 16'hFFFF by forced errors, then another error -> stays 16'hFFFF. Assert err_clr in the same cycle as an error -> err_count=1. Pull rst=0 while LOCKED -> all outputs 0 on the next edge.
